// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-owner request scheduler in front of the byte-serial
//            memory controller. Arbitrates between instruction block fetches,
//            loads and committed stores. Fixed priority is store > load > fetch.
//            Exactly one transaction is outstanding at a time.
//            Rollback cancels speculative traffic, which means fetch and load.
//            Committed stores always run to completion.
//
// Optional : MEM_ARB_STARVE_GUARD_EN - when defined, a saturating counter
//            tracks how long a fetch has waited. When the counter reaches
//            STARVE_LIMIT, fetch wins the next arbitration outright.
//
// Ports    : clk, rst            clock, synchronous active-high reset
//            rdy                 global enable (low freezes everything)
//            rollback            pipeline flush
//            if_req_*            fetch request (64-byte block, mc_len = 0)
//            ld_req_*            load request (len 1/2/4)
//            st_req_*            committed store request
//            io_buffer_full      blocks stores to the IO window (addr[17:16]=11)
//            *_grant / *_done    one-cycle pulses per requester
//            ld_data             load result, updated on each load done
//            mc_*                command to / completion from memory controller
//
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_grant,
    output logic              if_done,

    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [2:0]        ld_req_len,
    output logic              ld_grant,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_data,

    input  logic              st_req_valid,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [2:0]        st_req_len,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              st_grant,
    output logic              st_done,

    input  logic              io_buffer_full,

    output logic              mc_valid,
    output logic [1:0]        mc_kind,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_len,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    localparam logic [1:0] c_KIND_FETCH = 2'd0;
    localparam logic [1:0] c_KIND_LOAD  = 2'd1;
    localparam logic [1:0] c_KIND_STORE = 2'd2;

    // The starvation counter is 5 bits wide, so the limit must fit in it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 31) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..31");
    end

    // ------------------------------------------------------------------------
    // Registers and combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_owner;

    logic              w_st_elig;
    logic              w_ld_elig;
    logic              w_if_elig;
    logic              w_starved;
    logic              w_any_elig;
    logic [1:0]        w_win_kind;

    logic              w_busy_cancel;

    logic              w_mc_valid_nxt;
    logic [1:0]        w_mc_kind_nxt;
    logic [ADDR_W-1:0] w_mc_addr_nxt;
    logic [2:0]        w_mc_len_nxt;
    logic [DATA_W-1:0] w_mc_wdata_nxt;
    logic [1:0]        w_owner_nxt;
    logic [DATA_W-1:0] w_ld_data_nxt;
    logic              w_if_grant_nxt;
    logic              w_ld_grant_nxt;
    logic              w_st_grant_nxt;
    logic              w_if_done_nxt;
    logic              w_ld_done_nxt;
    logic              w_st_done_nxt;

    // ------------------------------------------------------------------------
    // Eligibility and priority select
    // ------------------------------------------------------------------------
    // A store to the IO window cannot issue while the IO buffer is full.
    // Speculative requests (load/fetch) are ignored during a flush.
    assign w_st_elig = st_req_valid &&
                       !((st_req_addr[17:16] == 2'b11) && io_buffer_full);
    assign w_ld_elig = ld_req_valid && !rollback;
    assign w_if_elig = if_req_valid && !rollback;

    always_comb begin
        w_win_kind = c_KIND_FETCH;
        w_any_elig = 1'b1;
        if (w_if_elig && w_starved) begin
            w_win_kind = c_KIND_FETCH;
        end else if (w_st_elig) begin
            w_win_kind = c_KIND_STORE;
        end else if (w_ld_elig) begin
            w_win_kind = c_KIND_LOAD;
        end else if (w_if_elig) begin
            w_win_kind = c_KIND_FETCH;
        end else begin
            w_any_elig = 1'b0;
        end
    end

    // A flush aborts an in-flight fetch or load. A committed store is immune.
    // The abort takes precedence over a coincident mc_done, so no done
    // pulse is produced for the aborted transaction.
    assign w_busy_cancel = rollback && (r_owner != c_KIND_STORE);

    // ------------------------------------------------------------------------
    // Fetch starvation guard
    // ------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [4:0] c_STARVE_MAX = 5'(STARVE_LIMIT);

    logic [4:0] r_starve_cnt;
    logic       w_fetch_won;

    assign w_starved   = (r_starve_cnt == c_STARVE_MAX);
    assign w_fetch_won = (r_state == c_IDLE) && w_any_elig &&
                         (w_win_kind == c_KIND_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 5'd0;
        end else if (rdy) begin
            if (rollback || !if_req_valid || w_fetch_won) begin
                r_starve_cnt <= 5'd0;
            end else if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 5'd1;
            end
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (rdy) begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_elig) begin
                        w_state_nxt = c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (w_busy_cancel || mc_done) begin
                        w_state_nxt = c_GAP;
                    end
                end
                // The GAP cycle lets the controller return to its own idle
                // state before it sees the next command.
                c_GAP:   w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic. This computes the next values of the registered
    // outputs. Command fields hold by default. Pulses default to zero, so
    // they are dropped entirely while rdy is low.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mc_valid_nxt = mc_valid;
        w_mc_kind_nxt  = mc_kind;
        w_mc_addr_nxt  = mc_addr;
        w_mc_len_nxt   = mc_len;
        w_mc_wdata_nxt = mc_wdata;
        w_owner_nxt    = r_owner;
        w_ld_data_nxt  = ld_data;
        w_if_grant_nxt = 1'b0;
        w_ld_grant_nxt = 1'b0;
        w_st_grant_nxt = 1'b0;
        w_if_done_nxt  = 1'b0;
        w_ld_done_nxt  = 1'b0;
        w_st_done_nxt  = 1'b0;

        if (rdy) begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_elig) begin
                        w_mc_valid_nxt = 1'b1;
                        w_mc_kind_nxt  = w_win_kind;
                        w_owner_nxt    = w_win_kind;
                        case (w_win_kind)
                            c_KIND_STORE: begin
                                w_mc_addr_nxt  = st_req_addr;
                                w_mc_len_nxt   = st_req_len;
                                w_mc_wdata_nxt = st_req_data;
                                w_st_grant_nxt = 1'b1;
                            end
                            c_KIND_LOAD: begin
                                w_mc_addr_nxt  = ld_req_addr;
                                w_mc_len_nxt   = ld_req_len;
                                w_mc_wdata_nxt = '0;
                                w_ld_grant_nxt = 1'b1;
                            end
                            default: begin
                                w_mc_addr_nxt  = if_req_addr;
                                w_mc_len_nxt   = 3'd0;
                                w_mc_wdata_nxt = '0;
                                w_if_grant_nxt = 1'b1;
                            end
                        endcase
                    end
                end
                c_BUSY: begin
                    if (w_busy_cancel) begin
                        w_mc_valid_nxt = 1'b0;
                    end else if (mc_done) begin
                        w_mc_valid_nxt = 1'b0;
                        case (r_owner)
                            c_KIND_STORE: w_st_done_nxt = 1'b1;
                            c_KIND_LOAD: begin
                                w_ld_done_nxt = 1'b1;
                                w_ld_data_nxt = mc_rdata;
                            end
                            default:      w_if_done_nxt = 1'b1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output and owner registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= c_KIND_FETCH;
            mc_valid <= 1'b0;
            mc_kind  <= 2'd0;
            mc_addr  <= '0;
            mc_len   <= 3'd0;
            mc_wdata <= '0;
            ld_data  <= '0;
            if_grant <= 1'b0;
            ld_grant <= 1'b0;
            st_grant <= 1'b0;
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            mc_valid <= w_mc_valid_nxt;
            mc_kind  <= w_mc_kind_nxt;
            mc_addr  <= w_mc_addr_nxt;
            mc_len   <= w_mc_len_nxt;
            mc_wdata <= w_mc_wdata_nxt;
            ld_data  <= w_ld_data_nxt;
            if_grant <= w_if_grant_nxt;
            ld_grant <= w_ld_grant_nxt;
            st_grant <= w_st_grant_nxt;
            if_done  <= w_if_done_nxt;
            ld_done  <= w_ld_done_nxt;
            st_done  <= w_st_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. The bench runs directed
//            scenarios followed by a randomized phase. Each cycle, a
//            transaction-level reference model predicts every output. The
//            model tracks four things: whether a transaction is in flight,
//            who owns it, whether the post-transaction gap is pending, and
//            how long the fetch has waited.
//            Honours MEM_ARB_STARVE_GUARD_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rdy, rollback;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_grant, if_done;
    logic          ld_req_valid;
    logic [AW-1:0] ld_req_addr;
    logic [2:0]    ld_req_len;
    logic          ld_grant, ld_done;
    logic [DW-1:0] ld_data;
    logic          st_req_valid;
    logic [AW-1:0] st_req_addr;
    logic [2:0]    st_req_len;
    logic [DW-1:0] st_req_data;
    logic          st_grant, st_done;
    logic          io_buffer_full;
    logic          mc_valid;
    logic [1:0]    mc_kind;
    logic [AW-1:0] mc_addr;
    logic [2:0]    mc_len;
    logic [DW-1:0] mc_wdata;
    logic          mc_done;
    logic [DW-1:0] mc_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_grant(if_grant), .if_done(if_done),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
        .ld_req_len(ld_req_len), .ld_grant(ld_grant), .ld_done(ld_done),
        .ld_data(ld_data),
        .st_req_valid(st_req_valid), .st_req_addr(st_req_addr),
        .st_req_len(st_req_len), .st_req_data(st_req_data),
        .st_grant(st_grant), .st_done(st_done),
        .io_buffer_full(io_buffer_full),
        .mc_valid(mc_valid), .mc_kind(mc_kind), .mc_addr(mc_addr),
        .mc_len(mc_len), .mc_wdata(mc_wdata),
        .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state. Kinds: 0 fetch, 1 load, 2 store.
    // Grant/done vectors are indexed by kind.
    bit            m_active;
    int            m_owner;
    bit            m_gap;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int            m_wait;
`endif
    logic          e_mc_valid;
    logic [1:0]    e_mc_kind;
    logic [AW-1:0] e_mc_addr;
    logic [2:0]    e_mc_len;
    logic [DW-1:0] e_mc_wdata;
    logic [DW-1:0] e_ld_data;
    logic [2:0]    e_grant;
    logic [2:0]    e_done;

    logic [2:0]    lens [3] = '{3'd1, 3'd2, 3'd4};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the inputs presented in the current cycle.
    task automatic model_eval();
        logic st_ok, ld_ok, if_ok, starved, fetch_won;
        int   w;
        e_grant   = 3'b000;
        e_done    = 3'b000;
        fetch_won = 1'b0;
        if (rst) begin
            m_active = 0; m_owner = 0; m_gap = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            m_wait = 0;
`endif
            e_mc_valid = 0; e_mc_kind = 0; e_mc_addr = 0; e_mc_len = 0;
            e_mc_wdata = 0; e_ld_data = 0;
            return;
        end
        if (!rdy) return;
        if (m_active) begin
            if (rollback && m_owner != 2) begin
                m_active = 0; m_gap = 1; e_mc_valid = 0;
            end else if (mc_done) begin
                m_active = 0; m_gap = 1; e_mc_valid = 0;
                e_done[m_owner] = 1'b1;
                if (m_owner == 1) e_ld_data = mc_rdata;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            st_ok = st_req_valid && !(st_req_addr[17:16] == 2'b11 && io_buffer_full);
            ld_ok = ld_req_valid && !rollback;
            if_ok = if_req_valid && !rollback;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starved = (m_wait == SL);
`else
            starved = 1'b0;
`endif
            w = -1;
            if (if_ok && starved) w = 0;
            else if (st_ok)       w = 2;
            else if (ld_ok)       w = 1;
            else if (if_ok)       w = 0;
            if (w >= 0) begin
                m_active   = 1;
                m_owner    = w;
                e_mc_valid = 1;
                e_mc_kind  = 2'(w);
                e_grant[w] = 1'b1;
                fetch_won  = (w == 0);
                case (w)
                    0: begin e_mc_addr = if_req_addr; e_mc_len = 3'd0; e_mc_wdata = '0; end
                    1: begin e_mc_addr = ld_req_addr; e_mc_len = ld_req_len; e_mc_wdata = '0; end
                    default: begin e_mc_addr = st_req_addr; e_mc_len = st_req_len; e_mc_wdata = st_req_data; end
                endcase
            end
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (rollback || !if_req_valid || fetch_won) m_wait = 0;
        else if (m_wait < SL) m_wait++;
`endif
    endtask

    task automatic compare_all();
        chk("grant",    64'({st_grant, ld_grant, if_grant}), 64'(e_grant));
        chk("done",     64'({st_done, ld_done, if_done}),    64'(e_done));
        chk("mc_valid", 64'(mc_valid),                       64'(e_mc_valid));
        chk("mc_kind_len", 64'({mc_kind, mc_len}),           64'({e_mc_kind, e_mc_len}));
        chk("mc_addr",  64'(mc_addr),                        64'(e_mc_addr));
        chk("mc_wdata", 64'(mc_wdata),                       64'(e_mc_wdata));
        chk("ld_data",  64'(ld_data),                        64'(e_ld_data));
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic finish_txn(input logic [DW-1:0] rdata);
        mc_rdata = rdata;
        mc_done  = 1'b1;
        step();
        mc_done  = 1'b0;
    endtask

    initial begin
        int  n_fg;
        bit  armed;
        int  lat;

        rst = 1; rdy = 1; rollback = 0; io_buffer_full = 0;
        if_req_valid = 0; if_req_addr = 0;
        ld_req_valid = 0; ld_req_addr = 0; ld_req_len = 0;
        st_req_valid = 0; st_req_addr = 0; st_req_len = 0; st_req_data = 0;
        mc_done = 0; mc_rdata = 0;
        armed = 0; lat = 0; n_fg = 0;

        // Reset
        step(); step();
        rst = 0;
        chk("rst_mc_valid", 64'(mc_valid), 64'd0);
        chk("rst_pulses", 64'({if_grant, ld_grant, st_grant, if_done, ld_done, st_done}), 64'd0);

        // Single fetch
        if_req_valid = 1; if_req_addr = 32'h100;
        step();
        chk("t1_if_grant", 64'(if_grant), 64'd1);
        chk("t1_kind", 64'(mc_kind), 64'd0);
        chk("t1_addr", 64'(mc_addr), 64'h100);
        chk("t1_len", 64'(mc_len), 64'd0);
        if_req_valid = 0;
        step();
        finish_txn(32'h0);
        chk("t1_if_done", 64'(if_done), 64'd1);
        chk("t1_valid_low", 64'(mc_valid), 64'd0);
        step(); step();

        // All three at once: store, then load, then fetch
        st_req_valid = 1; st_req_addr = 32'h1000; st_req_len = 3'd4; st_req_data = 32'h11223344;
        ld_req_valid = 1; ld_req_addr = 32'h2000; ld_req_len = 3'd4;
        if_req_valid = 1; if_req_addr = 32'h300;
        step();
        chk("t2_st_first", 64'({st_grant, ld_grant, if_grant}), 64'b100);
        chk("t2_st_wdata", 64'(mc_wdata), 64'h11223344);
        st_req_valid = 0;
        finish_txn(32'h0);
        chk("t2_st_done", 64'(st_done), 64'd1);
        step();
        chk("t2_gap", 64'(mc_valid), 64'd0);
        step();
        chk("t2_ld_second", 64'({st_grant, ld_grant, if_grant}), 64'b010);
        chk("t2_ld_len", 64'(mc_len), 64'd4);
        ld_req_valid = 0;
        finish_txn(32'hDEADBEEF);
        chk("t3_ld_done", 64'(ld_done), 64'd1);
        chk("t3_ld_data", 64'(ld_data), 64'hDEADBEEF);
        step(); step();
        chk("t2_if_third", 64'({st_grant, ld_grant, if_grant}), 64'b001);
        if_req_valid = 0;
        finish_txn(32'h0);
        step(); step();

        // IO-window store blocked by a full IO buffer
        st_req_valid = 1; st_req_addr = 32'h30000; st_req_len = 3'd1; st_req_data = 32'hAB;
        io_buffer_full = 1;
        ld_req_valid = 1; ld_req_addr = 32'h44; ld_req_len = 3'd2;
        step();
        chk("t4_ld_wins", 64'({st_grant, ld_grant}), 64'b01);
        ld_req_valid = 0;
        finish_txn(32'h5555);
        step(); step();
        chk("t4_store_blocked", 64'(mc_valid), 64'd0);
        io_buffer_full = 0;
        step();
        chk("t4_st_grant", 64'(st_grant), 64'd1);
        st_req_valid = 0;
        finish_txn(32'h0);
        step(); step();

        // Rollback cancels a load
        ld_req_valid = 1; ld_req_addr = 32'h80; ld_req_len = 3'd1;
        step();
        chk("t5_ld_grant", 64'(ld_grant), 64'd1);
        ld_req_valid = 0; rollback = 1;
        step();
        rollback = 0;
        chk("t5_ld_cancel", 64'(mc_valid), 64'd0);
        chk("t5_no_done", 64'(ld_done), 64'd0);
        step(); step();
        chk("t5_ld_data_kept", 64'(ld_data), 64'h5555);

        // Rollback does not affect a store
        st_req_valid = 1; st_req_addr = 32'h500; st_req_len = 3'd2; st_req_data = 32'hBEEF;
        step();
        st_req_valid = 0; rollback = 1;
        step();
        chk("t5_st_hold", 64'(mc_valid), 64'd1);
        finish_txn(32'h0);
        rollback = 0;
        chk("t5_st_done", 64'(st_done), 64'd1);
        step(); step();

        // Rollback coincident with mc_done on a fetch suppresses done
        if_req_valid = 1; if_req_addr = 32'h700;
        step();
        if_req_valid = 0; rollback = 1;
        finish_txn(32'h0);
        rollback = 0;
        chk("t5_if_suppr", 64'({if_done, mc_valid}), 64'b00);
        step(); step();

        // rdy low freezes
        rdy = 0; if_req_valid = 1; if_req_addr = 32'h900;
        step();
        chk("t6_frozen", 64'({if_grant, mc_valid}), 64'b00);
        rdy = 1;
        step();
        chk("t6_grant", 64'(if_grant), 64'd1);
        if_req_valid = 0; rdy = 0;
        step();
        chk("t6_hold", 64'({if_grant, mc_valid}), 64'b01);
        rdy = 1;
        finish_txn(32'h0);
        chk("t6_done", 64'(if_done), 64'd1);
        step(); step();

        // Continuous stores competing with a fetch
        if_req_valid = 1; if_req_addr = 32'hA00;
        st_req_valid = 1; st_req_addr = 32'h1000; st_req_len = 3'd4; st_req_data = 32'h77;
        for (int i = 0; i < 60; i++) begin
            step();
            if (if_grant) begin n_fg++; if_req_valid = 0; end
            st_req_valid = !st_grant;
            mc_done = mc_valid;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("t7_fetch_under_stores", 64'(n_fg), 64'd1);
`else
        chk("t7_fetch_under_stores", 64'(n_fg), 64'd0);
`endif
        st_req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if_grant) begin n_fg++; if_req_valid = 0; end
            mc_done = mc_valid;
        end
        chk("t7_fetch_total", 64'(n_fg), 64'd1);
        mc_done = 0;
        step(); step(); step();

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            step();
            if (if_grant) if_req_valid = 0;
            else if (!if_req_valid && $urandom_range(0, 3) == 0) begin
                if_req_valid = 1; if_req_addr = $urandom;
            end
            if (ld_grant) ld_req_valid = 0;
            else if (!ld_req_valid && $urandom_range(0, 3) == 0) begin
                ld_req_valid = 1; ld_req_addr = $urandom;
                ld_req_len = lens[$urandom_range(0, 2)];
            end
            if (st_grant) st_req_valid = 0;
            else if (!st_req_valid && $urandom_range(0, 3) == 0) begin
                st_req_valid = 1; st_req_addr = $urandom;
                if ($urandom_range(0, 1) == 1) st_req_addr[17:16] = 2'b11;
                st_req_len = lens[$urandom_range(0, 2)];
                st_req_data = $urandom;
            end
            rdy            = ($urandom_range(0, 9) != 0);
            rollback       = ($urandom_range(0, 15) == 0);
            io_buffer_full = ($urandom_range(0, 3) == 0);
            mc_done = 0;
            if (!mc_valid) begin
                armed = 0;
            end else begin
                if (!armed) begin armed = 1; lat = $urandom_range(0, 4); end
                if (rdy) begin
                    if (lat == 0) begin mc_done = 1; mc_rdata = $urandom; end
                    else lat--;
                end
            end
        end

        rdy = 1; rollback = 0; mc_done = 0;
        if_req_valid = 0; ld_req_valid = 0; st_req_valid = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-owner request scheduler in front of the byte-serial memory controller. Accepts block fetches from the instruction fetcher and loads/stores from the load-store buffer. Arbitrates by fixed priority with an optional fetch starvation guard and holds one transaction outstanding at a time. Handles rollback by cancelling speculative traffic; committed stores always run to completion.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, load/store data width
- STARVE_LIMIT, 16, cycles of waiting fetch before fetch is forced to top priority (5-bit counter, legal 1..31)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  pipeline flush
- if_req_valid / if_req_addr  in  1 / ADDR_W  fetch request (64-byte block)
- if_grant, if_done  out  1  one-cycle pulses: request accepted / block delivered
- ld_req_valid / ld_req_addr / ld_req_len  in  1 / ADDR_W / 3  load request; len ∈ {1,2,4}
- ld_grant, ld_done  out  1  pulses
- ld_data  out  DATA_W  load result; valid with ld_done
- st_req_valid / st_req_addr / st_req_len / st_req_data  in  1 / ADDR_W / 3 / DATA_W  committed store
- st_grant, st_done  out  1  pulses
- io_buffer_full  in  1  IO output buffer full
- mc_valid  out  1  command to memory controller, held until mc_done
- mc_kind  out  2  0 fetch, 1 load, 2 store
- mc_addr / mc_len / mc_wdata  out  ADDR_W / 3 / DATA_W  command fields (mc_len = 0 for fetch)
- mc_done / mc_rdata  in  1 / DATA_W  controller completion pulse and load data

## Operation
- States: IDLE, BUSY, GAP. Owner register records the granted kind.
- IDLE: eligible set = store if st_req_valid and not (st_req_addr[17:16]==2'b11 and io_buffer_full); load if ld_req_valid and not rollback; fetch if if_req_valid and not rollback. Priority store > load > fetch (see Configuration). Winner fields are latched into mc_*; mc_valid←1; owner←winner; the winner's grant pulses next cycle; → BUSY. No eligible requester: stay in IDLE.
- Requester holds valid and fields stable until it sees its grant, and drops valid in the grant cycle.
- BUSY: mc_* stable. On mc_done: mc_valid←0; owner's done pulses next cycle; for load, ld_data←mc_rdata; → GAP.
- GAP: one idle cycle so the controller returns to IDLE; → IDLE.
- Rollback in BUSY with owner fetch/load: mc_valid←0, no done, → GAP. Rollback with owner store: ignored.
- Rollback coincident with mc_done for fetch/load: done suppressed.
- rdy low: state, counters and mc_* hold; grant/done pulses are not generated.
- Reset: state IDLE, owner fetch, all outputs 0, starvation counter 0.

## Timing
- Request sampled in cycle t: mc_valid and grant high at t+1.
- mc_done at cycle d: done pulse and mc_valid low at d+1; earliest next mc_valid at d+3.
- Arbiter adds 3 cycles of overhead per transaction beyond controller latency.
- Grant and done are each exactly one cycle wide; ld_data holds until the next load done.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter increments each cycle if_req_valid is high and the fetch is not granted, saturating at STARVE_LIMIT. At STARVE_LIMIT, fetch wins the next IDLE arbitration over load and store. The counter clears on fetch grant, on rollback, or when if_req_valid is low.
- Undefined: pure fixed priority store > load > fetch; no counter logic.

## Test plan
- Reset, then if_req_valid with addr 0x100 → if_grant at t+1, mc_kind=0, mc_addr=0x100; mc_done → if_done next cycle, GAP, then IDLE.
- Store, load and fetch all valid at once → store granted first, then load, then fetch, each separated by GAP.
- Load addr 0x2000 len 4, mc_rdata=0xDEADBEEF → ld_done with ld_data=0xDEADBEEF.
- Store to 0x30000 with io_buffer_full=1 and load pending → load granted. Store granted after io_buffer_full drops.
- Rollback during a BUSY load → mc_valid drops next cycle, no ld_done. Rollback during a BUSY store → store completes and st_done pulses.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4 and continuous stores plus a fetch → fetch is granted after the counter reaches 4, ahead of the next store. Without the macro, fetch waits until stores stop.
